// File: rtl/mem_req_master.sv
// Command-queued initiator for a 16x4 chip-select memory: buffers write/read/clear
// commands in a small FIFO, sequences them onto the memory pins and returns read data.
module mem_req_master #(
  parameter int unsigned DW    = 4,
  parameter int unsigned AW    = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          mem_cs,
  output logic          mem_wrt,
  output logic          mem_rd,
  output logic          mem_clr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  typedef enum logic [1:0] {StIdle, StIssue, StCapt, StResp} state_e;
  state_e state_q;

  logic [1:0]    fifo_op    [DEPTH];
  logic [AW-1:0] fifo_addr  [DEPTH];
  logic [DW-1:0] fifo_wdata [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic       push, pop, load, empty, head_go;
  logic [1:0] head_op;

  assign empty     = (count_q == '0);
  assign req_ready = (count_q != CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign head_op   = fifo_op[rd_ptr_q];
  assign head_go   = !empty && (head_op != OpNop);
  assign busy      = !empty || (state_q != StIdle);

  // Idle pops anything (NOPs are dropped); other exits pop only a real command.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      StIdle:  pop = !empty;
      StIssue: pop = !mem_rd && head_go;
      StResp:  pop = rsp_ready && head_go;
      default: pop = 1'b0;
    endcase
  end

  assign load = pop && (head_op != OpNop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr_q]    <= req_op;
      fifo_addr[wr_ptr_q]  <= req_addr;
      fifo_wdata[wr_ptr_q] <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mem_cs    <= 1'b0;
      mem_wrt   <= 1'b0;
      mem_rd    <= 1'b0;
      mem_clr   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
    end else begin
      mem_cs  <= 1'b0;
      mem_wrt <= 1'b0;
      mem_rd  <= 1'b0;
      mem_clr <= 1'b0;
      case (state_q)
        StIdle: begin
          if (load) state_q <= StIssue;
        end
        StIssue: begin
          // mem_rd is only high while a READ is being issued.
          if (mem_rd) state_q <= StCapt;
          else        state_q <= load ? StIssue : StIdle;
        end
        StCapt: begin
          rsp_data  <= mem_rdata;
          rsp_addr  <= mem_addr;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= load ? StIssue : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (load) begin
        mem_cs <= 1'b1;
        case (head_op)
          OpWrite: begin
            mem_wrt   <= 1'b1;
            mem_addr  <= fifo_addr[rd_ptr_q];
            mem_wdata <= fifo_wdata[rd_ptr_q];
          end
          OpRead: begin
            mem_rd   <= 1'b1;
            mem_addr <= fifo_addr[rd_ptr_q];
          end
          OpClear: mem_clr <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_req_master.sv
// Directed bench for mem_req_master with a behavioural 16x4 memory attached.
module tb_mem_req_master;

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [3:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_data, rsp_addr;
  logic       mem_cs, mem_wrt, mem_rd, mem_clr;
  logic [3:0] mem_addr, mem_wdata, mem_rdata;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cs_cnt = 0;
  int clr_cnt = 0;
  int clr_bad = 0;
  int rsp_cnt = 0;

  logic [3:0] mem_model [16];

  always #5 clk = ~clk;

  mem_req_master #(.DW(4), .AW(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .mem_cs    (mem_cs),
    .mem_wrt   (mem_wrt),
    .mem_rd    (mem_rd),
    .mem_clr   (mem_clr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Synchronous memory: write/read need cs, clear wipes the whole array.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem_model[i] <= 4'h0;
    end else if (mem_cs && mem_wrt) begin
      mem_model[mem_addr] <= mem_wdata;
    end
    if (mem_cs && mem_rd) mem_rdata <= mem_model[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_cs) cs_cnt <= cs_cnt + 1;
    if (mem_clr) clr_cnt <= clr_cnt + 1;
    if (mem_clr && !mem_cs) clr_bad <= clr_bad + 1;
    if (rsp_valid && rsp_ready && !rst) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] addr, input logic [3:0] data);
    int k = 0;
    req_op    = op;
    req_addr  = addr;
    req_wdata = data;
    req_valid = 1'b1;
    while (!req_ready && k < 50) begin
      tick();
      k++;
    end
    if (k == 50) check("send_ready_timeout", 32'(req_ready), 32'h1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 50) begin
      tick();
      k++;
    end
    check("idle_timeout", 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, b0, r0, s0, k;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = OpNop;
    req_addr  = 4'h0;
    req_wdata = 4'h0;
    rsp_ready = 1'b1;
    #50;
    rst = 1'b0;
    #1;
    check("rst_mem_cs",    32'(mem_cs),    32'h0);
    check("rst_mem_wrt",   32'(mem_wrt),   32'h0);
    check("rst_mem_rd",    32'(mem_rd),    32'h0);
    check("rst_mem_clr",   32'(mem_clr),   32'h0);
    check("rst_mem_addr",  32'(mem_addr),  32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data",  32'(rsp_data),  32'h0);
    check("rst_rsp_addr",  32'(rsp_addr),  32'h0);
    tick();

    // Write then read back; check exact cycle timing.
    send(OpWrite, 4'h9, 4'hB);
    check("w_acc_cs", 32'(mem_cs), 32'h0);
    check("w_acc_busy", 32'(busy), 32'h1);
    tick();
    check("w_wrt", 32'(mem_wrt), 32'h1);
    check("w_cs", 32'(mem_cs), 32'h1);
    check("w_addr", 32'(mem_addr), 32'h9);
    check("w_wdata", 32'(mem_wdata), 32'hB);
    send(OpRead, 4'h9, 4'h0);
    check("w_wrt_drop", 32'(mem_wrt), 32'h0);
    check("r_e0_cs", 32'(mem_cs), 32'h0);
    tick();
    check("r_rd", 32'(mem_rd), 32'h1);
    check("r_cs", 32'(mem_cs), 32'h1);
    check("r_addr", 32'(mem_addr), 32'h9);
    tick();
    check("r_capt_cs", 32'(mem_cs), 32'h0);
    check("r_capt_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    check("r_rsp_valid", 32'(rsp_valid), 32'h1);
    check("r_rsp_data", 32'(rsp_data), 32'hB);
    check("r_rsp_addr", 32'(rsp_addr), 32'h9);
    tick();
    check("r_rsp_done", 32'(rsp_valid), 32'h0);
    check("r_idle", 32'(busy), 32'h0);

    // Two writes, clear, read: clear zeroes the word just written.
    c0 = clr_cnt; b0 = clr_bad; r0 = rsp_cnt;
    send(OpWrite, 4'hB, 4'h3);
    send(OpWrite, 4'h5, 4'hF);
    send(OpClear, 4'h0, 4'h0);
    send(OpRead, 4'h5, 4'h0);
    k = 0;
    while (!rsp_valid && k < 20) begin
      tick();
      k++;
    end
    check("clr_rsp_valid", 32'(rsp_valid), 32'h1);
    check("clr_rsp_data", 32'(rsp_data), 32'h0);
    check("clr_rsp_addr", 32'(rsp_addr), 32'h5);
    wait_idle();
    check("clr_pulses", 32'(clr_cnt - c0), 32'h1);
    check("clr_without_cs", 32'(clr_bad - b0), 32'h0);
    check("clr_rsp_count", 32'(rsp_cnt - r0), 32'h1);
    check("clr_mem_b", 32'(mem_model[11]), 32'h0);

    // Stalled response: FIFO fills, nothing issues until rsp_ready.
    send(OpWrite, 4'h9, 4'h6);
    wait_idle();
    rsp_ready = 1'b0;
    send(OpRead, 4'h9, 4'h0);
    for (int i = 1; i <= 4; i++) send(OpWrite, 4'(i), 4'(i));
    check("bp_full_ready", 32'(req_ready), 32'h0);
    check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
    s0 = cs_cnt;
    repeat (5) tick();
    check("bp_no_cs", 32'(cs_cnt - s0), 32'h0);
    check("bp_rsp_hold", 32'(rsp_valid), 32'h1);
    check("bp_rsp_data", 32'(rsp_data), 32'h6);
    check("bp_rsp_addr", 32'(rsp_addr), 32'h9);
    check("bp_still_full", 32'(req_ready), 32'h0);
    rsp_ready = 1'b1;
    tick();
    check("bp_rsp_clear", 32'(rsp_valid), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("bp_wrt%0d", i), 32'(mem_wrt), 32'h1);
      check($sformatf("bp_addr%0d", i), 32'(mem_addr), 32'(i));
      tick();
    end
    wait_idle();
    for (int i = 1; i <= 4; i++) check($sformatf("bp_mem%0d", i), 32'(mem_model[i]), 32'(i));

    // NOP between writes is dropped silently.
    s0 = cs_cnt; r0 = rsp_cnt;
    send(OpWrite, 4'h6, 4'hA);
    send(OpNop, 4'h7, 4'h5);
    send(OpWrite, 4'h8, 4'hC);
    wait_idle();
    check("nop_cs_cycles", 32'(cs_cnt - s0), 32'h2);
    check("nop_no_rsp", 32'(rsp_cnt - r0), 32'h0);
    check("nop_mem6", 32'(mem_model[6]), 32'hA);
    check("nop_mem7", 32'(mem_model[7]), 32'h0);
    check("nop_mem8", 32'(mem_model[8]), 32'hC);

    // Reset in the capture cycle discards the response and the queue.
    r0 = rsp_cnt;
    send(OpRead, 4'h6, 4'h0);
    send(OpWrite, 4'hC, 4'h7);
    send(OpWrite, 4'hD, 4'h7);
    check("mr_capt_cs", 32'(mem_cs), 32'h0);
    rst = 1'b1;
    #1;
    s0 = cs_cnt;
    check("mr_cs", 32'(mem_cs), 32'h0);
    check("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mr_req_ready", 32'(req_ready), 32'h1);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_mem_addr", 32'(mem_addr), 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("mr_no_cs", 32'(cs_cnt - s0), 32'h0);
    check("mr_no_rsp", 32'(rsp_cnt - r0), 32'h0);
    check("mr_mem_c", 32'(mem_model[12]), 32'h0);
    check("mr_mem_d", 32'(mem_model[13]), 32'h0);
    check("mr_idle", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
